// File: rtl/vga_pkg.sv
// Shared timing defaults (640x480@60), sync polarity constants and total-count helpers
// for the VGA timing generator.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam logic POL_NEG = 1'b0;
    localparam logic POL_POS = 1'b1;

    function automatic int h_total(input int act, input int fp, input int sy, input int bp);
        return act + fp + sy + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sy, input int bp);
        return act + fp + sy + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-qualified shift register with async reset to a configurable value.
// DEPTH of 0 degenerates to a wire.
module vga_delay_line #(
    parameter int           W       = 1,
    parameter int           DEPTH   = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_shift
            logic [DEPTH-1:0][W-1:0] r_sr;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
                end else if (i_en) begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
                end
            end

            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: counters, sync, markers, and colour re-alignment.
// Optional colour-bar test pattern is built when VGA_TIMING_TESTPAT_EN is defined.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic H_POL    = POL_NEG,
    parameter logic V_POL    = POL_NEG,
    parameter int   COLOR_W  = 8,
    parameter int   PIPE     = 2,
    localparam int  H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int  V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int  XW       = $clog2(H_TOTAL),
    localparam int  YW       = $clog2(V_TOTAL)
) (
    input  logic               pxlClk,
    input  logic               rst,
    input  logic               pxlEn,
`ifdef VGA_TIMING_TESTPAT_EN
    input  logic               testPat,
`endif
    input  logic [COLOR_W-1:0] rIn,
    input  logic [COLOR_W-1:0] gIn,
    input  logic [COLOR_W-1:0] bIn,
    output logic [XW-1:0]      pxlX,
    output logic [YW-1:0]      pxlY,
    output logic               active,
    output logic               frameStart,
    output logic               lineStart,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               hSync,
    output logic               vSync
);

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
`ifdef VGA_TIMING_TESTPAT_EN
    localparam int DW       = 6;
    localparam int BAR_W    = H_ACTIVE / 8;
`else
    localparam int DW       = 3;
`endif

    generate
        if (H_SYNC < 1 || V_SYNC < 1 || PIPE < 0 || PIPE > 8) begin : g_param_err
            $error("vga_timing_gen: H_SYNC/V_SYNC must be >= 1 and PIPE in 0..8");
        end
    endgenerate

    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic               r_lineStart, r_frameStart;
    logic               w_active, w_hs, w_vs;
    logic [DW-1:0]      w_s0, w_dly;
    logic [COLOR_W-1:0] w_r, w_g, w_b;
    logic [COLOR_W-1:0] r_r, r_g, r_b;
    logic               r_hs, r_vs;

    always_ff @(posedge pxlClk or posedge rst) begin
        if (rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end else if (pxlEn) begin
            r_lineStart  <= (r_x == '0);
            r_frameStart <= (r_x == '0) && (r_y == '0);
            if (r_x == XW'(H_TOTAL - 1)) begin
                r_x <= '0;
                r_y <= (r_y == YW'(V_TOTAL - 1)) ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    assign w_active = (r_x < XW'(H_ACTIVE)) && (r_y < YW'(V_ACTIVE));
    assign w_hs = (r_x >= XW'(HS_START) && r_x < XW'(HS_END)) ? H_POL : ~H_POL;
    assign w_vs = (r_y >= YW'(VS_START) && r_y < YW'(VS_END)) ? V_POL : ~V_POL;

    // Bar index rides the same delay line so it lands with its own active/sync bits.
`ifdef VGA_TIMING_TESTPAT_EN
    assign w_s0 = {3'(r_x / XW'(BAR_W)), w_active, w_hs, w_vs};
`else
    assign w_s0 = {w_active, w_hs, w_vs};
`endif

    vga_delay_line #(
        .W       (DW),
        .DEPTH   (PIPE),
        .RST_VAL (DW'({1'b0, ~H_POL, ~V_POL}))
    ) u_dly (
        .i_clk (pxlClk),
        .i_rst (rst),
        .i_en  (pxlEn),
        .i_d   (w_s0),
        .o_q   (w_dly)
    );

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_dly[2]) begin
`ifdef VGA_TIMING_TESTPAT_EN
            if (testPat) begin
                w_r = {COLOR_W{w_dly[5]}};
                w_g = {COLOR_W{w_dly[4]}};
                w_b = {COLOR_W{w_dly[3]}};
            end else begin
                w_r = rIn;
                w_g = gIn;
                w_b = bIn;
            end
`else
            w_r = rIn;
            w_g = gIn;
            w_b = bIn;
`endif
        end
    end

    always_ff @(posedge pxlClk or posedge rst) begin
        if (rst) begin
            r_r  <= '0;
            r_g  <= '0;
            r_b  <= '0;
            r_hs <= ~H_POL;
            r_vs <= ~V_POL;
        end else if (pxlEn) begin
            r_r  <= w_r;
            r_g  <= w_g;
            r_b  <= w_b;
            r_hs <= w_dly[1];
            r_vs <= w_dly[0];
        end
    end

    assign pxlX       = r_x;
    assign pxlY       = r_y;
    assign active     = w_active;
    assign lineStart  = r_lineStart;
    assign frameStart = r_frameStart;
    assign R          = r_r;
    assign G          = r_g;
    assign B          = r_b;
    assign hSync      = r_hs;
    assign vSync      = r_vs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench on a shrunk raster (24x10): dut1 negative sync, PIPE=2; dut2 positive sync, PIPE=0.
// Define VGA_TIMING_TESTPAT_EN to also exercise the colour bars.
module tb_vga_timing_gen;

    logic       pxlClk, rst, pxlEn;
    logic [7:0] rIn, gIn, bIn;
`ifdef VGA_TIMING_TESTPAT_EN
    logic       testPat;
`endif

    logic [4:0] x1, x2;
    logic [3:0] y1, y2;
    logic       act1, act2, fs1, fs2, ls1, ls2, hs1, hs2, vs1, vs2;
    logic [7:0] R1, G1, B1, R2, G2, B2;

    int checks = 0;
    int errors = 0;
    int k = 0;

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .COLOR_W(8), .PIPE(2)
    ) dut1 (
        .pxlClk(pxlClk), .rst(rst), .pxlEn(pxlEn),
`ifdef VGA_TIMING_TESTPAT_EN
        .testPat(testPat),
`endif
        .rIn(rIn), .gIn(gIn), .bIn(bIn),
        .pxlX(x1), .pxlY(y1), .active(act1), .frameStart(fs1), .lineStart(ls1),
        .R(R1), .G(G1), .B(B1), .hSync(hs1), .vSync(vs1)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .COLOR_W(8), .PIPE(0)
    ) dut2 (
        .pxlClk(pxlClk), .rst(rst), .pxlEn(pxlEn),
`ifdef VGA_TIMING_TESTPAT_EN
        .testPat(testPat),
`endif
        .rIn(rIn), .gIn(gIn), .bIn(bIn),
        .pxlX(x2), .pxlY(y2), .active(act2), .frameStart(fs2), .lineStart(ls2),
        .R(R2), .G(G2), .B(B2), .hSync(hs2), .vSync(vs2)
    );

    initial pxlClk = 1'b0;
    always #5 pxlClk = ~pxlClk;

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge pxlClk);
            #1;
            if (pxlEn) k++;
        end
    endtask

    task automatic adv_to(input int target);
        adv(target - k);
    endtask

    task automatic test_reset;
        rst = 1'b1; pxlEn = 1'b1;
        rIn = 8'hAA; gIn = 8'h55; bIn = 8'h0F;
`ifdef VGA_TIMING_TESTPAT_EN
        testPat = 1'b0;
`endif
        adv(3);
        checks++; if (x1 !== 5'd0 || y1 !== 4'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", x1, y1); end
        checks++; if (act1 !== 1'b1) begin errors++; $display("FAIL reset_active: got %b want 1", act1); end
        checks++; if (fs1 !== 1'b0 || ls1 !== 1'b0) begin errors++; $display("FAIL reset_markers: got fs=%b ls=%b want 0,0", fs1, ls1); end
        checks++; if (R1 !== 8'h00 || G1 !== 8'h00 || B1 !== 8'h00) begin errors++; $display("FAIL reset_rgb: got %h%h%h want 000000", R1, G1, B1); end
        checks++; if (hs1 !== 1'b1 || vs1 !== 1'b1) begin errors++; $display("FAIL reset_sync_neg: got %b%b want 11", hs1, vs1); end
        checks++; if (hs2 !== 1'b0 || vs2 !== 1'b0) begin errors++; $display("FAIL reset_sync_pos: got %b%b want 00", hs2, vs2); end
        rst = 1'b0;
        k = 0;
    endtask

    task automatic test_start;
        adv(1);
        checks++; if (x1 !== 5'd1 || y1 !== 4'd0) begin errors++; $display("FAIL start_xy: got %0d,%0d want 1,0", x1, y1); end
        checks++; if (ls1 !== 1'b1 || fs1 !== 1'b1) begin errors++; $display("FAIL start_pulse: got ls=%b fs=%b want 1,1", ls1, fs1); end
        checks++; if (R1 !== 8'h00) begin errors++; $display("FAIL start_r_pipe2_k1: got %h want 00", R1); end
        checks++; if (R2 !== 8'hAA) begin errors++; $display("FAIL start_r_pipe0_k1: got %h want aa", R2); end
        adv(1);
        checks++; if (ls1 !== 1'b0 || fs1 !== 1'b0) begin errors++; $display("FAIL start_pulse_end: got ls=%b fs=%b want 0,0", ls1, fs1); end
        checks++; if (R1 !== 8'h00) begin errors++; $display("FAIL start_r_pipe2_k2: got %h want 00", R1); end
        adv(1);
        checks++; if (R1 !== 8'hAA || G1 !== 8'h55 || B1 !== 8'h0F) begin errors++; $display("FAIL start_rgb_k3: got %h%h%h want aa550f", R1, G1, B1); end
    endtask

    task automatic test_hsync;
        int m;
        adv_to(24);
        checks++; if (x1 !== 5'd0 || y1 !== 4'd1) begin errors++; $display("FAIL hwrap_xy: got %0d,%0d want 0,1", x1, y1); end
        checks++; if (ls1 !== 1'b0) begin errors++; $display("FAIL hwrap_ls_before: got %b want 0", ls1); end
        for (int n = 25; n <= 48; n++) begin
            adv(1);
            m = k % 24;
            checks++; if (hs1 !== ((m >= 21) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL hsync_neg k=%0d: got %b want %b", k, hs1, (m >= 21) ? 1'b0 : 1'b1); end
            checks++; if (hs2 !== ((m >= 19 && m <= 21) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL hsync_pos k=%0d: got %b", k, hs2); end
            if (k == 25) begin
                checks++; if (ls1 !== 1'b1 || fs1 !== 1'b0) begin errors++; $display("FAIL line2_pulse: got ls=%b fs=%b want 1,0", ls1, fs1); end
            end
            if (k == 40) begin
                checks++; if (act1 !== 1'b0) begin errors++; $display("FAIL active_x16: got %b want 0", act1); end
            end
        end
        checks++; if (x1 !== 5'd0 || y1 !== 4'd2) begin errors++; $display("FAIL hline2_xy: got %0d,%0d want 0,2", x1, y1); end
    endtask

    task automatic test_color;
        int m;
        logic [7:0] vr, vg, vb;
        for (int n = 49; n <= 72; n++) begin
            vr = 8'(n); vg = ~8'(n); vb = 8'(n) ^ 8'h5A;
            rIn = vr; gIn = vg; bIn = vb;
            adv(1);
            m = k % 24;
            checks++;
            if ((m >= 3 && m <= 18) ? (R1 !== vr || G1 !== vg || B1 !== vb) : (R1 !== 8'h00 || G1 !== 8'h00 || B1 !== 8'h00)) begin
                errors++; $display("FAIL color_pipe2 k=%0d: got %h%h%h in %h%h%h", k, R1, G1, B1, vr, vg, vb);
            end
            checks++;
            if ((m >= 1 && m <= 16) ? (R2 !== vr || G2 !== vg || B2 !== vb) : (R2 !== 8'h00 || G2 !== 8'h00 || B2 !== 8'h00)) begin
                errors++; $display("FAIL color_pipe0 k=%0d: got %h%h%h in %h%h%h", k, R2, G2, B2, vr, vg, vb);
            end
        end
        rIn = 8'hAA; gIn = 8'h55; bIn = 8'h0F;
        adv_to(123);
        checks++; if (R1 !== 8'hAA || G1 !== 8'h55) begin errors++; $display("FAIL last_visible_line: got %h%h want aa55", R1, G1); end
        adv_to(147);
        checks++; if (R1 !== 8'h00) begin errors++; $display("FAIL blank_line6: got %h want 00", R1); end
    endtask

    task automatic test_vsync;
        adv_to(168);
        checks++; if (vs2 !== 1'b0) begin errors++; $display("FAIL vsync_pos_k168: got %b want 0", vs2); end
        adv_to(169);
        checks++; if (vs2 !== 1'b1) begin errors++; $display("FAIL vsync_pos_k169: got %b want 1", vs2); end
        adv_to(170);
        checks++; if (vs1 !== 1'b1) begin errors++; $display("FAIL vsync_neg_k170: got %b want 1", vs1); end
        adv_to(171);
        checks++; if (vs1 !== 1'b0) begin errors++; $display("FAIL vsync_neg_k171: got %b want 0", vs1); end
        adv_to(216);
        checks++; if (vs2 !== 1'b1) begin errors++; $display("FAIL vsync_pos_k216: got %b want 1", vs2); end
        adv_to(217);
        checks++; if (vs2 !== 1'b0) begin errors++; $display("FAIL vsync_pos_k217: got %b want 0", vs2); end
        adv_to(218);
        checks++; if (vs1 !== 1'b0) begin errors++; $display("FAIL vsync_neg_k218: got %b want 0", vs1); end
        adv_to(219);
        checks++; if (vs1 !== 1'b1) begin errors++; $display("FAIL vsync_neg_k219: got %b want 1", vs1); end
    endtask

    task automatic test_frame;
        adv_to(240);
        checks++; if (x1 !== 5'd0 || y1 !== 4'd0) begin errors++; $display("FAIL frame_wrap_xy: got %0d,%0d want 0,0", x1, y1); end
        checks++; if (fs1 !== 1'b0) begin errors++; $display("FAIL frame_fs_k240: got %b want 0", fs1); end
        adv_to(241);
        checks++; if (fs1 !== 1'b1 || ls1 !== 1'b1) begin errors++; $display("FAIL frame_fs_k241: got fs=%b ls=%b want 1,1", fs1, ls1); end
    endtask

    task automatic test_enable;
        pxlEn = 1'b0;
        adv(3);
        checks++; if (fs1 !== 1'b1 || ls1 !== 1'b1 || x1 !== 5'd1) begin errors++; $display("FAIL en_hold_pulse: got fs=%b ls=%b x=%0d want 1,1,1", fs1, ls1, x1); end
        for (int n = 0; n < 20; n++) begin
            pxlEn = 1'b1; adv(1);
            pxlEn = 1'b0; adv(3);
        end
        checks++; if (x1 !== 5'd21 || y1 !== 4'd0) begin errors++; $display("FAIL en_quarter_xy: got %0d,%0d want 21,0", x1, y1); end
        checks++; if (hs1 !== 1'b0 || R1 !== 8'h00) begin errors++; $display("FAIL en_hold_sync: got hs=%b R=%h want 0,00", hs1, R1); end
        for (int n = 0; n < 6; n++) begin
            pxlEn = 1'b1; adv(1);
            pxlEn = 1'b0; adv(3);
        end
        checks++; if (x1 !== 5'd3 || y1 !== 4'd1 || R1 !== 8'hAA) begin errors++; $display("FAIL en_hold_color: got x=%0d y=%0d R=%h want 3,1,aa", x1, y1, R1); end
        pxlEn = 1'b1;
    endtask

    task automatic test_reset_mid;
        adv_to(285);
        checks++; if (hs1 !== 1'b0 || hs2 !== 1'b1) begin errors++; $display("FAIL pre_reset_sync: got %b%b want 01", hs1, hs2); end
        rst = 1'b1;
        #1;
        checks++; if (x1 !== 5'd0 || y1 !== 4'd0) begin errors++; $display("FAIL midrst_xy: got %0d,%0d want 0,0", x1, y1); end
        checks++; if (hs1 !== 1'b1 || vs1 !== 1'b1 || hs2 !== 1'b0) begin errors++; $display("FAIL midrst_sync: got %b%b%b want 110", hs1, vs1, hs2); end
        checks++; if (R1 !== 8'h00 || ls1 !== 1'b0) begin errors++; $display("FAIL midrst_rgb: got R=%h ls=%b want 00,0", R1, ls1); end
        adv(1);
        rst = 1'b0;
        k = 0;
        adv(1);
        checks++; if (x1 !== 5'd1 || ls1 !== 1'b1 || fs1 !== 1'b1) begin errors++; $display("FAIL post_rst: got x=%0d ls=%b fs=%b want 1,1,1", x1, ls1, fs1); end
    endtask

`ifdef VGA_TIMING_TESTPAT_EN
    task automatic test_testpat;
        testPat = 1'b1;
        adv_to(2);
        checks++; if ({R2, G2, B2} !== 24'h000000) begin errors++; $display("FAIL bar0: got %h%h%h want 000000", R2, G2, B2); end
        adv_to(6);
        checks++; if ({R2, G2, B2} !== 24'h00FF00) begin errors++; $display("FAIL bar2: got %h%h%h want 00ff00", R2, G2, B2); end
        adv_to(16);
        checks++; if ({R2, G2, B2} !== 24'hFFFFFF) begin errors++; $display("FAIL bar7: got %h%h%h want ffffff", R2, G2, B2); end
        adv_to(17);
        checks++; if ({R2, G2, B2} !== 24'h000000) begin errors++; $display("FAIL bar_blank: got %h%h%h want 000000", R2, G2, B2); end
        testPat = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_start;
        test_hsync;
        test_color;
        test_vsync;
        test_frame;
        test_enable;
        test_reset_mid;
`ifdef VGA_TIMING_TESTPAT_EN
        test_testpat;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
